// File: rtl/keypad_scan_ctrl.sv
// Column-scan sequencer for a 5x4 active-low matrix keypad.
// Debounces press and release, latches the key code and flags it until read.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       readn,
  input  logic [3:0] Key_y,
  output logic [4:0] Key_x,
  output logic [4:0] Key_out,
  output logic       Key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      col_q, col_d;
  logic [1:0]      row_q, row_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dwell_q;
  logic [3:0]      ysync1_q, ysync2_q;
  logic [4:0]      kout_q, kout_d;
  logic            ready_q, ready_d;
  logic            held_q, held_d;
  logic            ovr_q, ovr_d;

  logic            sample;
  logic            row_low;
  logic            cnt_done;
  logic            latch;
  logic [2:0]      col_nxt;
  logic [1:0]      low_row;
  logic [CW-1:0]   cnt_inc;

  assign sample   = (dwell_q == DW'(SCAN_DIV - 1));
  assign row_low  = ~ysync2_q[row_q];
  assign cnt_done = (cnt_q >= CW'(DEBOUNCE_CNT - 1));
  assign cnt_inc  = (cnt_q == CW'(DEBOUNCE_CNT)) ?
                    cnt_q : cnt_q + 1'b1;
  assign col_nxt  = (col_q == 3'd4) ? 3'd0 : col_q + 3'd1;

  // Lowest-index low row wins when several are pressed
  always_comb begin
    low_row = 2'd3;
    priority case (1'b1)
      !ysync2_q[0]: low_row = 2'd0;
      !ysync2_q[1]: low_row = 2'd1;
      !ysync2_q[2]: low_row = 2'd2;
      default:      low_row = 2'd3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    latch   = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (sample) begin
          if (ysync2_q == 4'hF) begin
            col_d = col_nxt;
          end else begin
            row_d   = low_row;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (sample) begin
          if (!row_low) begin
            col_d   = col_nxt;
            state_d = SCAN;
          end else if (cnt_done) begin
            latch   = 1'b1;
            held_d  = 1'b1;
            cnt_d   = '0;
            state_d = HELD;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      HELD: begin
        if (sample) begin
          if (row_low) begin
            cnt_d = '0;
          end else if (cnt_done) begin
            held_d  = 1'b0;
            col_d   = col_nxt;
            state_d = SCAN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // A fresh code beats a same-cycle acknowledge
  always_comb begin
    kout_d  = latch ? {col_q, row_q} : kout_q;
    ready_d = latch ? 1'b1 : (!readn ? 1'b0 : ready_q);
    ovr_d   = !readn ? 1'b0 :
              ((latch && ready_q) ? 1'b1 : ovr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SCAN;
      col_q    <= '0;
      row_q    <= '0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      ysync1_q <= 4'hF;
      ysync2_q <= 4'hF;
      kout_q   <= '0;
      ready_q  <= 1'b0;
      held_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      dwell_q  <= sample ? '0 : dwell_q + 1'b1;
      ysync1_q <= Key_y;
      ysync2_q <= ysync1_q;
      kout_q   <= kout_d;
      ready_q  <= ready_d;
      held_q   <= held_d;
      ovr_q    <= ovr_d;
    end
  end

  assign Key_x     = ~(5'b00001 << col_q);
  assign Key_out   = kout_q;
  assign Key_ready = ready_q;
  assign key_held  = held_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl (SCAN_DIV=4, DEBOUNCE_CNT=3).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       readn;
  logic [3:0] Key_y;
  logic [4:0] Key_x;
  logic [4:0] Key_out;
  logic       Key_ready;
  logic       key_held;
  logic       overrun;

  int n_cmp;
  int n_err;

  logic [4:0] xs [5];

  keypad_scan_ctrl #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .readn    (readn),
    .Key_y    (Key_y),
    .Key_x    (Key_x),
    .Key_out  (Key_out),
    .Key_ready(Key_ready),
    .key_held (key_held),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  // Returns at the falling edge just after column x becomes driven
  task automatic wait_col(input logic [4:0] x);
    int n;
    n = 0;
    while (Key_x == x && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (Key_x != x && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (Key_x != x) chk("wait_col", Key_x, x);
  endtask

  // Press lands at S0 = +4, latch at +16, release done at +28
  task automatic press(input logic [4:0] x, input logic [3:0] y,
                       input bit ack);
    wait_col(x);
    Key_y = y;
    repeat (15) @(negedge clk);
    if (ack) readn = 1'b0;
    @(negedge clk);
    readn = 1'b1;
    Key_y = 4'hF;
    repeat (12) @(negedge clk);
    chk("rel_held", key_held, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    xs[0] = 5'b11110;
    xs[1] = 5'b11101;
    xs[2] = 5'b11011;
    xs[3] = 5'b10111;
    xs[4] = 5'b01111;
    rst   = 1'b1;
    readn = 1'b1;
    Key_y = 4'hF;
    #1;
    chk("rst_x", Key_x, 5'b11110);
    chk("rst_out", Key_out, 0);
    chk("rst_rdy", Key_ready, 0);
    chk("rst_held", key_held, 0);
    chk("rst_ovr", overrun, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // idle scan, including wrap back to column 0
    for (int i = 0; i < 24; i++) begin
      chk("scan_x", Key_x, xs[(i / 4) % 5]);
      if (i % 4 == 0) chk("idle_rdy", Key_ready, 0);
      @(negedge clk);
    end

    // col 2 row 1: latency, code, release
    wait_col(5'b11011);
    Key_y = 4'b1101;
    repeat (15) @(negedge clk);
    chk("t2_frozen", Key_x, 5'b11011);
    chk("t2_rdy_early", Key_ready, 0);
    @(negedge clk);
    chk("t2_rdy", Key_ready, 1);
    chk("t2_out", Key_out, 9);
    chk("t2_held", key_held, 1);
    Key_y = 4'hF;
    repeat (11) @(negedge clk);
    chk("t2_held_late", key_held, 1);
    @(negedge clk);
    chk("t2_released", key_held, 0);
    chk("t2_resume", Key_x, 5'b10111);
    chk("t2_rdy_kept", Key_ready, 1);

    readn = 1'b0;
    @(negedge clk);
    readn = 1'b1;
    chk("ack_rdy", Key_ready, 0);
    chk("ack_ovr", overrun, 0);

    // bounce: low for detection sample plus one, then high
    wait_col(5'b11011);
    Key_y = 4'b1101;
    repeat (9) @(negedge clk);
    Key_y = 4'hF;
    repeat (2) @(negedge clk);
    chk("t3_frozen", Key_x, 5'b11011);
    @(negedge clk);
    chk("t3_resume", Key_x, 5'b10111);
    chk("t3_rdy", Key_ready, 0);
    repeat (20) @(negedge clk);
    chk("t3_rdy_late", Key_ready, 0);
    chk("t3_held", key_held, 0);

    // unread key overwritten
    press(5'b01111, 4'b0111, 1'b0);
    chk("t4_out19", Key_out, 19);
    chk("t4_rdy", Key_ready, 1);
    chk("t4_ovr0", overrun, 0);
    press(5'b11110, 4'b1110, 1'b0);
    chk("t4_out0", Key_out, 0);
    chk("t4_ovr1", overrun, 1);
    readn = 1'b0;
    @(negedge clk);
    readn = 1'b1;
    chk("t4_ovr_clr", overrun, 0);
    chk("t4_rdy_clr", Key_ready, 0);

    // two rows low: lowest wins
    press(5'b11101, 4'b1010, 1'b0);
    chk("t5_out4", Key_out, 4);
    chk("t5_rdy", Key_ready, 1);
    press(5'b11110, 4'b1010, 1'b1);
    chk("t5_out0", Key_out, 0);
    chk("t5_rdy_kept", Key_ready, 1);
    chk("t5_ovr", overrun, 0);

    // async reset mid-debounce
    wait_col(5'b11011);
    Key_y = 4'b1101;
    repeat (6) @(negedge clk);
    chk("t6_frozen", Key_x, 5'b11011);
    rst = 1'b1;
    #1;
    chk("t6_x", Key_x, 5'b11110);
    chk("t6_out", Key_out, 0);
    chk("t6_rdy", Key_ready, 0);
    chk("t6_held", key_held, 0);
    chk("t6_ovr", overrun, 0);
    Key_y = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("t6_col0", Key_x, 5'b11110);
    repeat (4) @(negedge clk);
    chk("t6_col1", Key_x, 5'b11101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
